// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown controller: IDLE/RUN/PAUSE/DONE sequencing with registered digit, LED and status outputs.
// Optional DONE_BLINK_EN: in DONE the LED bus toggles on every tick instead of staying solid.
module countdown_ctrl #(
    parameter int unsigned INIT_TENS = 3,
    parameter int unsigned INIT_ONES = 0,
    parameter int unsigned LED_W     = 16
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             start_pulse,
    input  logic             clear_pulse,
    input  logic             tick,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0,
    output logic [LED_W-1:0] led,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] PRESET_TENS = INIT_TENS[3:0];
    localparam logic [3:0] PRESET_ONES = INIT_ONES[3:0];
    localparam logic       PRESET_ZERO = (INIT_TENS == 0) && (INIT_ONES == 0);

    if ((INIT_TENS > 9) || (INIT_ONES > 9)) begin : g_bad_preset
        $error("countdown_ctrl: INIT_TENS/INIT_ONES must each be a BCD digit (0..9)");
    end

    // Decrement a two-digit BCD value by one second, saturating at 00.
    function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if ((tens == 4'd0) && (ones == 4'd0)) begin
            res = 8'h00;
        end else if (ones != 4'd0) begin
            res = {tens, ones - 4'd1};
        end else begin
            res = {tens - 4'd1, 4'd9};
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [3:0]       digit1_r, digit0_r, digit1_s, digit0_s;
    logic [LED_W-1:0] led_r, led_s;
    logic             running_r, done_r, running_s, done_s;
    logic             last_sec_s;
    logic [7:0]       dec_s;

    assign last_sec_s = (digit1_r == 4'd0) && (digit0_r == 4'd1);
    assign dec_s      = bcd_dec(digit1_r, digit0_r);

    // State register.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; clear outranks start, start outranks tick.
    always_comb begin
        next_state_s = state_r;
        if (clear_pulse) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_pulse) begin
                        next_state_s = PRESET_ZERO ? ST_DONE : ST_RUN;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (start_pulse) begin
                        next_state_s = ST_PAUSE;
                    end else if (tick && last_sec_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (start_pulse) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_PAUSE;
                    end
                end
                ST_DONE: next_state_s = ST_DONE;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Next output values, computed from the upcoming state so outputs land with it.
    always_comb begin
        digit1_s  = digit1_r;
        digit0_s  = digit0_r;
        led_s     = '0;
        running_s = (next_state_s == ST_RUN);
        done_s    = (next_state_s == ST_DONE);
        if (clear_pulse) begin
            digit1_s = PRESET_TENS;
            digit0_s = PRESET_ONES;
        end else if ((state_r == ST_RUN) && !start_pulse && tick) begin
            digit1_s = dec_s[7:4];
            digit0_s = dec_s[3:0];
        end else begin
            digit1_s = digit1_r;
            digit0_s = digit0_r;
        end
        if (next_state_s != ST_DONE) begin
            led_s = '0;
        end else if (state_r != ST_DONE) begin
            led_s = '1;
        end else begin
`ifdef DONE_BLINK_EN
            led_s = tick ? ~led_r : led_r;
`else
            led_s = '1;
`endif
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            digit1_r  <= PRESET_TENS;
            digit0_r  <= PRESET_ONES;
            led_r     <= '0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            digit1_r  <= digit1_s;
            digit0_r  <= digit0_s;
            led_r     <= led_s;
            running_r <= running_s;
            done_r    <= done_s;
        end
    end

    assign digit1  = digit1_r;
    assign digit0  = digit0_r;
    assign led     = led_r;
    assign running = running_r;
    assign done    = done_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: a seconds-remaining model checked every cycle plus literal spot checks.
// Honours DONE_BLINK_EN for the expected LED behaviour in DONE.
module tb_countdown_ctrl;

    logic        clk = 1'b0;
    logic        rst_p = 1'b0;
    logic        start_pulse = 1'b0, clear_pulse = 1'b0, tick = 1'b0;
    logic        start0 = 1'b0, clear0 = 1'b0;
    logic [3:0]  digit1, digit0, d0_digit1, d0_digit0;
    logic [15:0] led, d0_led;
    logic        running, done, d0_running, d0_done;

    int n_checks = 0;
    int n_errors = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    countdown_ctrl #(.INIT_TENS(3), .INIT_ONES(0), .LED_W(16)) dut (
        .clk(clk), .rst_p(rst_p), .start_pulse(start_pulse), .clear_pulse(clear_pulse),
        .tick(tick), .digit1(digit1), .digit0(digit0), .led(led),
        .running(running), .done(done)
    );

    countdown_ctrl #(.INIT_TENS(0), .INIT_ONES(0), .LED_W(16)) dut0 (
        .clk(clk), .rst_p(rst_p), .start_pulse(start0), .clear_pulse(clear0),
        .tick(tick), .digit1(d0_digit1), .digit0(d0_digit0), .led(d0_led),
        .running(d0_running), .done(d0_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef DONE_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    // Model: seconds remaining and a mode (0 idle, 1 run, 2 pause, 3 done).
    localparam int PRESET = 30;
    int rem = PRESET;
    int mode = 0;
    bit led_on = 1'b0;

    always @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            rem = PRESET; mode = 0; led_on = 1'b0;
        end else if (clear_pulse) begin
            rem = PRESET; mode = 0; led_on = 1'b0;
        end else begin
            case (mode)
                0: if (start_pulse) begin
                    if (rem == 0) begin mode = 3; led_on = 1'b1; end
                    else mode = 1;
                end
                1: if (start_pulse) mode = 2;
                   else if (tick) begin
                       rem = rem - 1;
                       if (rem == 0) begin mode = 3; led_on = 1'b1; end
                   end
                2: if (start_pulse) mode = 1;
                3: if (tick && BLINK) led_on = !led_on;
                default: mode = 0;
            endcase
        end
    end

    // Compare the DUT with the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("digit1", {28'd0, digit1}, rem / 10);
            chk("digit0", {28'd0, digit0}, rem % 10);
            chk("running", {31'd0, running}, {31'd0, mode == 1});
            chk("done", {31'd0, done}, {31'd0, mode == 3});
            chk("led", {16'd0, led}, led_on ? 32'h0000_FFFF : 32'd0);
        end
    end

    task automatic step(input logic s, input logic c, input logic t);
        start_pulse = s; clear_pulse = c; tick = t;
        @(posedge clk);
        #1;
        start_pulse = 1'b0; clear_pulse = 1'b0; tick = 1'b0;
    endtask

    logic [15:0] blink_seq [4];

    initial begin
        if (BLINK) blink_seq = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        else       blink_seq = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        #1 rst_p = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_p = 1'b0;
        check_en = 1'b1;
        chk("reset_digits", {24'd0, digit1, digit0}, 32'h30);
        chk("reset_status", {14'd0, led, running, done}, 32'd0);

        // Full countdown 30 -> 00, then ticks in DONE.
        step(1'b1, 1'b0, 1'b0);
        chk("start_running", {31'd0, running}, 32'd1);
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (i == 1)  chk("tick1", {24'd0, digit1, digit0}, 32'h29);
            if (i == 10) chk("tick10", {24'd0, digit1, digit0}, 32'h20);
            if (i == 11) chk("tick11", {24'd0, digit1, digit0}, 32'h19);
            if (i == 29) chk("tick29_not_done", {31'd0, done}, 32'd0);
        end
        chk("done_digits", {24'd0, digit1, digit0}, 32'h00);
        chk("done_flags", {30'd0, running, done}, 32'd1);
        chk("done_led", {16'd0, led}, 32'hFFFF);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("blink_led", {16'd0, led}, {16'd0, blink_seq[i]});
            chk("done_hold", {24'd0, digit1, digit0}, 32'h00);
        end

        // Clear from DONE with start and tick coincident.
        step(1'b1, 1'b1, 1'b1);
        chk("clear_done", {24'd0, digit1, digit0}, 32'h30);
        chk("clear_done_status", {14'd0, led, running, done}, 32'd0);

        // Pause / resume.
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b1);
        chk("run25", {24'd0, digit1, digit0}, 32'h25);
        step(1'b1, 1'b0, 1'b0);
        chk("paused", {31'd0, running}, 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("pause_hold", {24'd0, digit1, digit0}, 32'h25);
        step(1'b1, 1'b0, 1'b0);
        chk("resumed", {31'd0, running}, 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("after_resume", {24'd0, digit1, digit0}, 32'h24);

        // Start and tick in the same cycle, in RUN then in PAUSE.
        repeat (12) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("pause_pair", {23'd0, running, digit1, digit0}, 32'h012);
        step(1'b1, 1'b0, 1'b1);
        chk("resume_pair", {23'd0, running, digit1, digit0}, 32'h112);
        step(1'b0, 1'b0, 1'b1);
        chk("after_pair", {24'd0, digit1, digit0}, 32'h11);

        // Clear wins over start and tick while running at 07.
        repeat (4) step(1'b0, 1'b0, 1'b1);
        chk("run07", {24'd0, digit1, digit0}, 32'h07);
        step(1'b1, 1'b1, 1'b1);
        chk("clear_run", {8'd0, led, digit1, digit0}, 32'h30);
        chk("clear_run_flags", {30'd0, running, done}, 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("idle_ignores_tick", {24'd0, digit1, digit0}, 32'h30);

        // Asynchronous reset mid-count at 15.
        step(1'b1, 1'b0, 1'b0);
        repeat (15) step(1'b0, 1'b0, 1'b1);
        chk("run15", {24'd0, digit1, digit0}, 32'h15);
        #1 rst_p = 1'b1;
        #1;
        chk("async_rst_digits", {24'd0, digit1, digit0}, 32'h30);
        chk("async_rst_status", {14'd0, led, running, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_p = 1'b0;

        // Preset 00 goes straight to DONE.
        chk("zero_idle", {13'd0, d0_done, d0_led, d0_digit1, d0_digit0} , 32'd0);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        chk("zero_done", {14'd0, d0_running, d0_done, d0_led}, 32'h1FFFF);
        chk("zero_digits", {24'd0, d0_digit1, d0_digit0}, 32'h00);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
